// File: rtl/wb_stream_master_arb.sv
// Round-robin Wishbone B3 arbiter. It shares one slave port between NUM_MASTERS
// stream DMA masters. A grant is held for the whole cycle or burst. A watchdog
// aborts a stalled transfer with ERR.
module wb_stream_master_arb #(
   parameter int NUM_MASTERS = 2,
   parameter int WB_AW       = 32,
   parameter int WB_DW       = 32,
   parameter int TIMEOUT     = 256
) (
   input  logic                         wb_clk_i,
   input  logic                         wb_rst_n_i,
   input  logic [NUM_MASTERS*WB_AW-1:0] wbm_adr_i,
   input  logic [NUM_MASTERS*WB_DW-1:0] wbm_dat_i,
   input  logic [NUM_MASTERS*WB_DW/8-1:0] wbm_sel_i,
   input  logic [NUM_MASTERS-1:0]       wbm_we_i,
   input  logic [NUM_MASTERS-1:0]       wbm_cyc_i,
   input  logic [NUM_MASTERS-1:0]       wbm_stb_i,
   input  logic [NUM_MASTERS*3-1:0]     wbm_cti_i,
   input  logic [NUM_MASTERS*2-1:0]     wbm_bte_i,
   output logic [WB_DW-1:0]             wbm_dat_o,
   output logic [NUM_MASTERS-1:0]       wbm_ack_o,
   output logic [NUM_MASTERS-1:0]       wbm_err_o,
   output logic [NUM_MASTERS-1:0]       wbm_rty_o,
   output logic [WB_AW-1:0]             wbs_adr_o,
   output logic [WB_DW-1:0]             wbs_dat_o,
   output logic [WB_DW/8-1:0]           wbs_sel_o,
   output logic                         wbs_we_o,
   output logic                         wbs_cyc_o,
   output logic                         wbs_stb_o,
   output logic [2:0]                   wbs_cti_o,
   output logic [1:0]                   wbs_bte_o,
   input  logic [WB_DW-1:0]             wbs_dat_i,
   input  logic                         wbs_ack_i,
   input  logic                         wbs_err_i,
   input  logic                         wbs_rty_i,
   output logic [NUM_MASTERS-1:0]       grant_o,
   output logic                         timeout_o
);
   localparam int SW = WB_DW / 8;
   localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [TW-1:0] T_LAST = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_GRANT = 2'd1
   } state_t;

   state_t                 state_reg;
   logic [NUM_MASTERS-1:0] grant_reg;
   logic [IW-1:0]          idx_reg;
   logic [IW-1:0]          last_reg;
   logic [TW-1:0]          timer_reg;

   // Per-master views of the packed input buses
   logic [WB_AW-1:0] adr_arr [NUM_MASTERS];
   logic [WB_DW-1:0] dat_arr [NUM_MASTERS];
   logic [SW-1:0]    sel_arr [NUM_MASTERS];
   logic [2:0]       cti_arr [NUM_MASTERS];
   logic [1:0]       bte_arr [NUM_MASTERS];

   generate
      for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_unpack
         assign adr_arr[gi] = wbm_adr_i[gi*WB_AW +: WB_AW];
         assign dat_arr[gi] = wbm_dat_i[gi*WB_DW +: WB_DW];
         assign sel_arr[gi] = wbm_sel_i[gi*SW +: SW];
         assign cti_arr[gi] = wbm_cti_i[gi*3 +: 3];
         assign bte_arr[gi] = wbm_bte_i[gi*2 +: 2];
      end
   endgenerate

   logic          granted, cyc_g, stb_g, resp, expire, release_now, found;
   logic [IW-1:0] pick;

   assign granted   = (state_reg == S_GRANT);
   assign cyc_g     = wbm_cyc_i[idx_reg];
   assign stb_g     = wbm_stb_i[idx_reg];
   assign resp      = wbs_ack_i | wbs_err_i | wbs_rty_i;
   // The watchdog fires on the TIMEOUT-th consecutive unanswered strobe cycle.
   // A slave response in the same cycle takes priority over the watchdog.
   assign expire    = (TIMEOUT != 0) && granted && cyc_g && stb_g && !resp &&
                      (timer_reg == T_LAST);
   assign release_now = !cyc_g || (wbs_ack_i && cti_arr[idx_reg] == 3'b111) ||
                        wbs_err_i || wbs_rty_i || expire;

   // Slave-side mux. The cycle is gated live by the owner's cyc and is killed when the watchdog fires.
   assign wbs_adr_o = adr_arr[idx_reg];
   assign wbs_dat_o = dat_arr[idx_reg];
   assign wbs_sel_o = sel_arr[idx_reg];
   assign wbs_we_o  = wbm_we_i[idx_reg];
   assign wbs_cti_o = cti_arr[idx_reg];
   assign wbs_bte_o = bte_arr[idx_reg];
   assign wbs_cyc_o = granted & cyc_g & ~expire;
   assign wbs_stb_o = granted & cyc_g & stb_g & ~expire;
   assign wbm_dat_o = wbs_dat_i;
   assign grant_o   = grant_reg;
   assign timeout_o = expire;

   // Route slave responses to the granted master only
   always_comb begin
      wbm_ack_o = '0;
      wbm_err_o = '0;
      wbm_rty_o = '0;
      if (granted) begin
         wbm_ack_o[idx_reg] = wbs_ack_i & stb_g;
         wbm_err_o[idx_reg] = (wbs_err_i & stb_g) | expire;
         wbm_rty_o[idx_reg] = wbs_rty_i & stb_g;
      end
   end

   // Round-robin search: the first requester after the last master that was served
   always_comb begin
      pick  = last_reg;
      found = 1'b0;
      for (int k = 1; k <= NUM_MASTERS; k++) begin
         if (!found && wbm_cyc_i[(int'(last_reg) + k) % NUM_MASTERS]) begin
            found = 1'b1;
            pick  = IW'((int'(last_reg) + k) % NUM_MASTERS);
         end
      end
   end

   // Arbitration FSM with watchdog timer; one idle cycle always separates grants
   always_ff @(posedge wb_clk_i) begin
      if (!wb_rst_n_i) begin
         state_reg <= S_IDLE;
         grant_reg <= '0;
         idx_reg   <= '0;
         last_reg  <= IW'(NUM_MASTERS - 1);
         timer_reg <= '0;
      end else begin
         case (state_reg)
            S_IDLE: begin
               if (found) begin
                  state_reg <= S_GRANT;
                  grant_reg <= {{(NUM_MASTERS-1){1'b0}}, 1'b1} << pick;
                  idx_reg   <= pick;
                  last_reg  <= pick;
                  timer_reg <= '0;
               end
            end
            S_GRANT: begin
               if (release_now) begin
                  state_reg <= S_IDLE;
                  grant_reg <= '0;
               end else if (resp) begin
                  timer_reg <= '0;
               end else if (cyc_g && stb_g) begin
                  timer_reg <= timer_reg + TW'(1);
               end
            end
            default: begin
               state_reg <= S_IDLE;
               grant_reg <= '0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_wb_stream_master_arb.sv
// Testbench for wb_stream_master_arb. Directed scenarios are followed by a randomized
// phase. Every cycle is checked against a transaction-level model of the arbiter.
module tb_wb_stream_master_arb;
   localparam int N  = 2;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int TO = 16;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [N*AW-1:0] m_adr_bus;
   logic [N*DW-1:0] m_dat_bus;
   logic [N*DW/8-1:0] m_sel_bus;
   logic [N-1:0]    m_we, m_cyc, m_stb;
   logic [N*3-1:0]  m_cti_bus;
   logic [N*2-1:0]  m_bte_bus;
   logic [DW-1:0]   m_dat_out;
   logic [N-1:0]    m_ack, m_err, m_rty;
   logic [AW-1:0]   s_adr;
   logic [DW-1:0]   s_dat_out, s_dat_in;
   logic [DW/8-1:0] s_sel;
   logic            s_we, s_cyc, s_stb;
   logic [2:0]      s_cti;
   logic [1:0]      s_bte;
   logic            s_ack, s_err, s_rty;
   logic [N-1:0]    grant;
   logic            tmo;

   wb_stream_master_arb #(.NUM_MASTERS(N), .WB_AW(AW), .WB_DW(DW), .TIMEOUT(TO)) dut (
      .wb_clk_i(clk), .wb_rst_n_i(rst_n),
      .wbm_adr_i(m_adr_bus), .wbm_dat_i(m_dat_bus), .wbm_sel_i(m_sel_bus),
      .wbm_we_i(m_we), .wbm_cyc_i(m_cyc), .wbm_stb_i(m_stb),
      .wbm_cti_i(m_cti_bus), .wbm_bte_i(m_bte_bus),
      .wbm_dat_o(m_dat_out), .wbm_ack_o(m_ack), .wbm_err_o(m_err), .wbm_rty_o(m_rty),
      .wbs_adr_o(s_adr), .wbs_dat_o(s_dat_out), .wbs_sel_o(s_sel), .wbs_we_o(s_we),
      .wbs_cyc_o(s_cyc), .wbs_stb_o(s_stb), .wbs_cti_o(s_cti), .wbs_bte_o(s_bte),
      .wbs_dat_i(s_dat_in), .wbs_ack_i(s_ack), .wbs_err_i(s_err), .wbs_rty_i(s_rty),
      .grant_o(grant), .timeout_o(tmo)
   );

   int checks = 0;
   int errors = 0;

   // Bench-side masters: one outstanding transfer each
   bit          ma_active [N];
   int          ma_left   [N];
   bit          ma_burst  [N];
   logic [31:0] ma_adr    [N];
   bit          ma_auto   [N];
   int          ma_delay  [N];
   int          ma_maxd   [N];

   // Arbiter model: current owner (-1 = none), last served master, unanswered strobe count
   int owner = -1;
   int last  = N - 1;
   int wait_cnt = 0;
   int grants[$];
   bit verbose = 1;

   // Slave behaviour: 0 ack always, 1 never respond, 2 random; err_at = beat that gets ERR
   int slave_mode = 0;
   int err_at = 0;
   int s_beat = 0;

   int obs_cyc = 0;
   int obs_to = 0;
   int obs_err [N];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [2:0] cur_cti(input int m);
      if (!ma_burst[m]) return 3'b000;
      return (ma_left[m] == 1) ? 3'b111 : 3'b010;
   endfunction

   task automatic start(input int m, input int len, input bit burst);
      ma_active[m] = 1;
      ma_left[m]   = len;
      ma_burst[m]  = burst;
      ma_adr[m]    = $urandom & 32'hFFFF_FFFC;
   endtask

   task automatic finish_xfer(input int m);
      ma_active[m] = 0;
      ma_delay[m]  = $urandom_range(0, ma_maxd[m]);
   endtask

   // Does the watchdog abort the transfer in the current cycle?
   function automatic bit expire_now();
      if (owner < 0 || TO == 0) return 0;
      return ma_active[owner] && !(s_ack | s_err | s_rty) && wait_cnt == TO - 1;
   endfunction

   // Put master and slave stimulus on the buses for this cycle
   task automatic drive();
      int r;
      for (int m = 0; m < N; m++) begin
         m_adr_bus[m*AW +: AW] = ma_adr[m];
         m_dat_bus[m*DW +: DW] = ma_adr[m] ^ 32'h5A5A_0000 ^ 32'(m);
         m_sel_bus[m*4 +: 4]   = 4'hF;
         m_we[m]               = (m == 1);
         m_cyc[m]              = ma_active[m];
         m_stb[m]              = ma_active[m];
         m_cti_bus[m*3 +: 3]   = ma_active[m] ? cur_cti(m) : 3'b000;
         m_bte_bus[m*2 +: 2]   = 2'b00;
      end
      s_ack = 0; s_err = 0; s_rty = 0;
      s_dat_in = $urandom;
      if (owner >= 0 && ma_active[owner]) begin
         s_beat++;
         if (err_at != 0 && s_beat == err_at) s_err = 1;
         else if (slave_mode == 0) s_ack = 1;
         else if (slave_mode == 2) begin
            r = $urandom_range(0, 99);
            if (r < 60) s_ack = 1;
            else if (r < 63) s_err = 1;
            else if (r < 66) s_rty = 1;
         end
      end
   endtask

   // Compare every DUT output with what the model predicts for this cycle
   task automatic check();
      logic [N-1:0] e_grant, e_ack, e_err, e_rty;
      bit ex, e_cyc;
      int g;
      ex = expire_now();
      g = owner;
      e_grant = '0; e_ack = '0; e_err = '0; e_rty = '0; e_cyc = 0;
      if (g >= 0) begin
         e_grant[g] = 1;
         e_ack[g]   = s_ack & ma_active[g];
         e_err[g]   = (s_err & ma_active[g]) | ex;
         e_rty[g]   = s_rty & ma_active[g];
         e_cyc      = ma_active[g] & !ex;
         chk("wbs_adr", 64'(s_adr), 64'(ma_adr[g]));
         chk("wbs_dat", 64'(s_dat_out), 64'(ma_adr[g] ^ 32'h5A5A_0000 ^ 32'(g)));
         chk("wbs_we", 64'(s_we), 64'(g == 1));
         if (ma_active[g]) chk("wbs_cti", 64'(s_cti), 64'(cur_cti(g)));
      end
      chk("grant", 64'(grant), 64'(e_grant));
      chk("wbs_cyc", 64'(s_cyc), 64'(e_cyc));
      chk("wbs_stb", 64'(s_stb), 64'(e_cyc));
      chk("ack", 64'(m_ack), 64'(e_ack));
      chk("err", 64'(m_err), 64'(e_err));
      chk("rty", 64'(m_rty), 64'(e_rty));
      chk("timeout", 64'(tmo), 64'(ex));
      chk("rdata", 64'(m_dat_out), 64'(s_dat_in));
      obs_cyc += int'(s_cyc);
      obs_to  += int'(tmo);
      for (int m = 0; m < N; m++) obs_err[m] += int'(m_err[m]);
   endtask

   // Advance model and masters across the clock edge using this cycle's inputs
   task automatic update();
      bit rel, ex;
      int g, c;
      if (!rst_n) begin
         owner = -1; last = N - 1; wait_cnt = 0;
         for (int m = 0; m < N; m++) ma_active[m] = 0;
         return;
      end
      if (owner < 0) begin
         for (int k = 1; k <= N; k++) begin
            c = (last + k) % N;
            if (owner < 0 && ma_active[c]) owner = c;
         end
         if (owner >= 0) begin
            last = owner; wait_cnt = 0; s_beat = 0;
            grants.push_back(owner);
            if (verbose) $display("t=%0t grant master %0d", $time, owner);
         end
      end else begin
         g  = owner;
         ex = expire_now();
         rel = !ma_active[g] || (s_ack && cur_cti(g) == 3'b111) || s_err || s_rty || ex;
         if (ma_active[g]) begin
            if (s_err || s_rty || ex) finish_xfer(g);
            else if (s_ack) begin
               ma_left[g]--;
               ma_adr[g] += 4;
               if (ma_left[g] == 0) finish_xfer(g);
            end
         end
         if (rel) owner = -1;
         else if (s_ack | s_err | s_rty) wait_cnt = 0;
         else wait_cnt++;
      end
      for (int m = 0; m < N; m++) begin
         if (!ma_active[m] && ma_auto[m]) begin
            if (ma_delay[m] == 0) start(m, $urandom_range(1, 8), 1'($urandom_range(0, 1)));
            else ma_delay[m]--;
         end
      end
   endtask

   task automatic cycle();
      drive();
      #1;
      check();
      @(posedge clk);
      update();
      @(negedge clk);
   endtask

   task automatic drain(input string tag);
      int n = 0;
      while ((ma_active[0] || ma_active[1] || owner >= 0) && n < 100) begin
         cycle();
         n++;
      end
      chk(tag, 64'(n < 100), 64'(1));
   endtask

   initial begin
      for (int m = 0; m < N; m++) begin
         ma_active[m] = 0; ma_left[m] = 0; ma_burst[m] = 0; ma_adr[m] = 0;
         ma_auto[m] = 0; ma_delay[m] = 0; ma_maxd[m] = 0; obs_err[m] = 0;
      end
      @(negedge clk);
      // Reset state
      repeat (3) cycle();
      chk("reset_grant", 64'(grant), 64'(0));
      rst_n = 1;

      // Simultaneous requests after reset: M0 first, then M1
      start(0, 2, 1); start(1, 2, 1);
      drain("drain_both");
      chk("first_after_reset", 64'(grants.size() > 0 ? grants[0] : 9), 64'(0));
      chk("second_grant", 64'(grants.size() > 1 ? grants[1] : 9), 64'(1));

      // Continuous requests from both masters alternate
      grants.delete();
      ma_auto[0] = 1; ma_auto[1] = 1;
      start(0, 3, 1); start(1, 3, 1);
      repeat (50) cycle();
      ma_auto[0] = 0; ma_auto[1] = 0;
      drain("drain_alt");
      for (int i = 1; i < 4; i++)
         chk("alternate", 64'(grants.size() > i ? grants[i] : 9),
             64'(grants.size() > i ? 1 - grants[i-1] : 0));

      // M0 alone, 8-beat incrementing burst, slave acks each beat
      obs_cyc = 0;
      start(0, 8, 1);
      drain("drain_burst8");
      chk("burst8_beats", 64'(obs_cyc), 64'(8));

      // M1 owns the bus, M0 requests mid-burst and must wait
      grants.delete();
      start(1, 6, 1);
      repeat (3) cycle();
      start(0, 2, 1);
      drain("drain_midreq");
      chk("midreq_order", 64'(grants.size() == 2 ? {grants[0], grants[1]} : 64'hFF), {32'd1, 32'd0});

      // Slave never answers: watchdog aborts
      slave_mode = 1; obs_to = 0; obs_err[0] = 0;
      start(0, 4, 1);
      drain("drain_timeout");
      chk("timeout_pulses", 64'(obs_to), 64'(1));
      chk("timeout_err_m0", 64'(obs_err[0]), 64'(1));
      slave_mode = 0;

      // Slave error on beat 3 goes to the granted master only
      err_at = 3; obs_err[0] = 0; obs_err[1] = 0;
      start(1, 8, 1);
      drain("drain_err");
      chk("err_m1", 64'(obs_err[1]), 64'(1));
      chk("err_m0", 64'(obs_err[0]), 64'(0));
      err_at = 0;

      // Classic multi-beat cycle keeps the grant until cyc drops
      start(1, 3, 0);
      drain("drain_classic");

      // Reset in the middle of a burst
      start(0, 8, 1);
      repeat (3) cycle();
      rst_n = 0;
      cycle();
      rst_n = 1;
      grants.delete();
      start(1, 2, 1); start(0, 2, 1);
      drain("drain_post_reset");
      chk("post_reset_first", 64'(grants.size() > 0 ? grants[0] : 9), 64'(0));

      // Randomized traffic with a random slave and occasional dead periods
      verbose = 0;
      slave_mode = 2;
      ma_maxd[0] = 3; ma_maxd[1] = 3;
      ma_auto[0] = 1; ma_auto[1] = 1;
      for (int i = 0; i < 3000; i++) begin
         slave_mode = ((i % 500) > 460) ? 1 : 2;
         cycle();
      end
      ma_auto[0] = 0; ma_auto[1] = 0;
      slave_mode = 0;
      drain("drain_random");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
